// File: rtl/win_pkg.sv
// Shared types and helpers for the 3x3 window generator.
// Tap numbering is row-major, w0 = top-left ... w8 = bottom-right.
package win_pkg;

    localparam int PIX_W   = 8;
    // Widest pixel the generic packing helper can handle.
    localparam int PIX_MAX = 16;

    typedef logic [PIX_W-1:0] pixel_t;

    localparam int WIN_TAPS = 9;
    localparam int W_TL = 0;
    localparam int W_TC = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_MC = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BC = 7;
    localparam int W_BR = 8;

    // Each row triple holds {right, centre, left} in PIX_MAX-wide slots,
    // left at the LSBs. The result packs pw-bit pixels densely from the LSB,
    // top row first, so bits above WIN_TAPS*pw are zero.
    function automatic logic [WIN_TAPS*PIX_MAX-1:0] pack_win(
        input logic [3*PIX_MAX-1:0] top,
        input logic [3*PIX_MAX-1:0] mid,
        input logic [3*PIX_MAX-1:0] bot,
        input int                   pw
    );
        logic [WIN_TAPS*PIX_MAX-1:0] res;
        logic [3*PIX_MAX-1:0]        src;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                src = top;
            end else if (r == 1) begin
                src = mid;
            end else begin
                src = bot;
            end
            for (int c = 0; c < 3; c++) begin
                for (int b = 0; b < PIX_MAX; b++) begin
                    if (b < pw) begin
                        res[(W_TL + r*3 + c)*pw + b] = src[c*PIX_MAX + b];
                    end
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/line_buf_2row.sv
// Two-row line buffer: DEPTH-deep, 2*PIX_W-wide single-port RAM holding
// {lb1, lb0}. Read is asynchronous, so the old word is seen in the same
// cycle it is overwritten (read-before-write). Contents are never cleared.
module line_buf_2row #(
    parameter int PIX_W  = 8,
    parameter int DEPTH  = 258,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [2*PIX_W-1:0]   wdata,
    output logic [2*PIX_W-1:0]   rdata
);

    logic [2*PIX_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Write the shifted column pair on every accepted pixel.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 window generator over a raster pixel stream of a padded
// image. Two line buffers supply rows r-2 / r-1; three tap columns form the
// window. One window per interior position, latency 1, full valid/ready.
// Optional macro WINGEN_LAST_EN adds out_eol / out_eof markers.
module window_gen_3x3
    import win_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 258,
    parameter int IMG_H = 34
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_pixel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*PIX_W-1:0]   out_win,
    output logic                 frame_done
`ifdef WINGEN_LAST_EN
    ,
    output logic                 out_eol,
    output logic                 out_eof
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic               accept;
    logic               col_last;
    logic               row_last;
    logic               win_cond;
    logic [2*PIX_W-1:0] lb_rd;
    logic [PIX_W-1:0]   lb1_rd;
    logic [PIX_W-1:0]   lb0_rd;

    // Tap columns: index 0 = top (row-2), 1 = mid (row-1), 2 = bottom (row).
    logic [PIX_W-1:0]   tap_l [3];
    logic [PIX_W-1:0]   tap_c [3];

    logic [3*PIX_MAX-1:0]        top_trip;
    logic [3*PIX_MAX-1:0]        mid_trip;
    logic [3*PIX_MAX-1:0]        bot_trip;
    logic [WIN_TAPS*PIX_MAX-1:0] win_full;
    logic [9*PIX_W-1:0]          win_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign col_last = (col == COL_W'(IMG_W - 1));
    assign row_last = (row == ROW_W'(IMG_H - 1));
    assign win_cond = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign lb1_rd   = lb_rd[2*PIX_W-1:PIX_W];
    assign lb0_rd   = lb_rd[PIX_W-1:0];

    line_buf_2row #(
        .PIX_W (PIX_W),
        .DEPTH (IMG_W),
        .ADDR_W(COL_W)
    ) u_lb (
        .clk  (clk),
        .we   (accept),
        .addr (col),
        .wdata({lb0_rd, in_pixel}),
        .rdata(lb_rd)
    );

    // Assemble the row triples (left, centre, new column) for packing.
    always_comb begin
        top_trip = '0;
        mid_trip = '0;
        bot_trip = '0;
        top_trip[0*PIX_MAX +: PIX_W] = tap_l[0];
        top_trip[1*PIX_MAX +: PIX_W] = tap_c[0];
        top_trip[2*PIX_MAX +: PIX_W] = lb1_rd;
        mid_trip[0*PIX_MAX +: PIX_W] = tap_l[1];
        mid_trip[1*PIX_MAX +: PIX_W] = tap_c[1];
        mid_trip[2*PIX_MAX +: PIX_W] = lb0_rd;
        bot_trip[0*PIX_MAX +: PIX_W] = tap_l[2];
        bot_trip[1*PIX_MAX +: PIX_W] = tap_c[2];
        bot_trip[2*PIX_MAX +: PIX_W] = in_pixel;
    end

    assign win_full = pack_win(top_trip, mid_trip, bot_trip, PIX_W);
    assign win_next = win_full[9*PIX_W-1:0];

    generate
        if (PIX_W < PIX_MAX) begin : g_pack_spare
            logic unused_pack_bits;
            assign unused_pack_bits = ^win_full[WIN_TAPS*PIX_MAX-1:9*PIX_W];
        end
    endgenerate

    // Raster counters, tap shift and output register with backpressure hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_win    <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                tap_l[i] <= '0;
                tap_c[i] <= '0;
            end
`ifdef WINGEN_LAST_EN
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
`endif
        end else begin
            frame_done <= accept && col_last && row_last;
            if (accept) begin
                tap_l[0] <= tap_c[0];
                tap_l[1] <= tap_c[1];
                tap_l[2] <= tap_c[2];
                tap_c[0] <= lb1_rd;
                tap_c[1] <= lb0_rd;
                tap_c[2] <= in_pixel;
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row <= '0;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end else begin
                    col <= col + COL_W'(1);
                end
                if (win_cond) begin
                    out_valid <= 1'b1;
                    out_win   <= win_next;
`ifdef WINGEN_LAST_EN
                    out_eol   <= col_last;
                    out_eof   <= col_last && row_last;
`endif
                end else begin
                    // Accepting implies any previous window was taken.
                    out_valid <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed self-checking bench for window_gen_3x3 on a 5x4 padded image.
module tb_window_gen_3x3;

    localparam int PW = 8;
    localparam int IW = 5;
    localparam int IH = 4;
    localparam int NPIX = IW * IH;
    localparam int NWIN = (IW - 2) * (IH - 2);

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_pixel;
    logic          out_valid;
    logic          out_ready;
    logic [9*PW-1:0] out_win;
    logic          frame_done;
`ifdef WINGEN_LAST_EN
    logic          out_eol;
    logic          out_eof;
`endif

    window_gen_3x3 #(.PIX_W(PW), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_win   (out_win),
        .frame_done(frame_done)
`ifdef WINGEN_LAST_EN
        ,
        .out_eol   (out_eol),
        .out_eof   (out_eof)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [PW-1:0]   fp [4][NPIX];
    logic [9*PW-1:0] got_win [$];
    bit              got_eol [$];
    bit              got_eof [$];
    bit              fd_exp = 1'b0;
    bit              hold_prev = 1'b0;
    logic [9*PW-1:0] prev_win;
    int              fd_cnt;

    localparam logic [71:0] WIN_FIRST  = 72'h0C0B0A_070605_020100;
    localparam logic [71:0] WIN_LAST   = 72'h131211_0E0D0C_090807;
    localparam logic [71:0] WIN_F2_1ST = 72'h706F6E_6B6A69_666564;

    // Reference 3x3 extraction: window g of frame f, row-major.
    function automatic logic [9*PW-1:0] model_win(input int f, input int j);
        logic [9*PW-1:0] w;
        int r, c;
        r = 2 + j / 3;
        c = 2 + j % 3;
        for (int k = 0; k < 9; k++) begin
            w[k*PW +: PW] = fp[f][(r - 2 + k / 3) * IW + (c - 2 + k % 3)];
        end
        return w;
    endfunction

    // One clock: drive inputs, observe at negedge, return whether pixel taken.
    task automatic step(input bit v, input bit ordy, input logic [PW-1:0] pix,
                        input bit is_last, input bit chk_stall, output bit acc);
        in_valid  = v;
        in_pixel  = pix;
        out_ready = ordy;
        @(negedge clk);
        n_cmp++;
        if (frame_done !== fd_exp) begin
            n_bad++;
            $display("FAIL frame_done: got %b expected %b", frame_done, fd_exp);
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (hold_prev) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_win !== prev_win) begin
                n_bad++;
                $display("FAIL hold_stable: got v=%b win=%h expected v=1 win=%h",
                         out_valid, out_win, prev_win);
            end
        end
        if (chk_stall) begin
            n_cmp += 2;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL stall_in_ready: got %b expected 0", in_ready);
            end
            if (out_win !== WIN_FIRST) begin
                n_bad++;
                $display("FAIL stall_win: got %h expected %h", out_win, WIN_FIRST);
            end
        end
        acc       = v && (in_ready === 1'b1);
        fd_exp    = acc && is_last;
        hold_prev = (out_valid === 1'b1) && !ordy;
        prev_win  = out_win;
        if (out_valid === 1'b1 && ordy) begin
            got_win.push_back(out_win);
`ifdef WINGEN_LAST_EN
            got_eol.push_back(out_eol);
            got_eof.push_back(out_eof);
`endif
        end
        @(posedge clk);
        #1;
    endtask

    // Stream nf frames from fp; mode 0 = full rate, 1 = 4-cycle stall on
    // first window, 2 = random valid/ready. Then check all windows.
    task automatic run(input int nf, input int mode);
        int  idx, cyc, stall_left;
        bit  v, ordy, cs, acc, stalled;
        got_win.delete();
        got_eol.delete();
        got_eof.delete();
        fd_cnt = 0;
        idx = 0; cyc = 0; stall_left = 0; stalled = 1'b0;
        while (idx < nf * NPIX && cyc < 3000) begin
            v = 1'b1; ordy = 1'b1; cs = 1'b0;
            if (mode == 1) begin
                if (!stalled && out_valid === 1'b1) begin
                    stalled = 1'b1;
                    stall_left = 4;
                end
                if (stall_left > 0) begin
                    ordy = 1'b0;
                    cs = 1'b1;
                    stall_left--;
                end
            end else if (mode == 2) begin
                v    = 1'($urandom_range(0, 1));
                ordy = 1'($urandom_range(0, 1));
            end
            step(v, ordy, fp[idx / NPIX][idx % NPIX], (idx % NPIX) == NPIX - 1, cs, acc);
            if (acc) idx++;
            cyc++;
        end
        n_cmp++;
        if (idx != nf * NPIX) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d pixels expected %0d", idx, nf * NPIX);
        end
        for (int d = 0; d < 4; d++) step(1'b0, 1'b1, '0, 1'b0, 1'b0, acc);
        n_cmp++;
        if (got_win.size() != nf * NWIN) begin
            n_bad++;
            $display("FAIL win_count: got %0d expected %0d", got_win.size(), nf * NWIN);
        end
        n_cmp++;
        if (fd_cnt != nf) begin
            n_bad++;
            $display("FAIL frame_done_count: got %0d expected %0d", fd_cnt, nf);
        end
        for (int g = 0; g < nf * NWIN && g < got_win.size(); g++) begin
            n_cmp++;
            if (got_win[g] !== model_win(g / NWIN, g % NWIN)) begin
                n_bad++;
                $display("FAIL window[%0d]: got %h expected %h", g, got_win[g],
                         model_win(g / NWIN, g % NWIN));
            end
`ifdef WINGEN_LAST_EN
            n_cmp += 2;
            if (got_eol[g] != ((g % NWIN) % 3 == 2)) begin
                n_bad++;
                $display("FAIL eol[%0d]: got %b expected %b", g, got_eol[g], (g % NWIN) % 3 == 2);
            end
            if (got_eof[g] != ((g % NWIN) == NWIN - 1)) begin
                n_bad++;
                $display("FAIL eof[%0d]: got %b expected %b", g, got_eof[g], (g % NWIN) == NWIN - 1);
            end
`endif
        end
    endtask

    task automatic fill_frame(input int f, input int base);
        for (int i = 0; i < NPIX; i++) fp[f][i] = PW'(base + i);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pixel = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_win !== '0) begin n_bad++; $display("FAIL reset_out_win: got %h expected 0", out_win); end
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        fill_frame(0, 0);
        run(1, 0);
        n_cmp += 2;
        if (got_win.size() > 0 && got_win[0] !== WIN_FIRST) begin
            n_bad++; $display("FAIL basic_first: got %h expected %h", got_win[0], WIN_FIRST);
        end
        if (got_win.size() > 5 && got_win[5] !== WIN_LAST) begin
            n_bad++; $display("FAIL basic_last: got %h expected %h", got_win[5], WIN_LAST);
        end
    endtask

    task automatic test_stall();
        fill_frame(0, 0);
        run(1, 1);
    endtask

    task automatic test_back_to_back();
        fill_frame(0, 0);
        fill_frame(1, 100);
        run(2, 0);
        n_cmp++;
        if (got_win.size() > 6 && got_win[6] !== WIN_F2_1ST) begin
            n_bad++; $display("FAIL b2b_first_f2: got %h expected %h", got_win[6], WIN_F2_1ST);
        end
    endtask

    task automatic test_mid_reset();
        bit acc;
        fill_frame(0, 0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b1, PW'(i), 1'b0, 1'b0, acc);
        rst_n = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fd_exp = 1'b0;
        hold_prev = 1'b0;
        n_cmp += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_done: got %b expected 0", frame_done); end
        run(1, 0);
        n_cmp++;
        if (got_win.size() > 0 && got_win[0] !== WIN_FIRST) begin
            n_bad++; $display("FAIL midrst_first: got %h expected %h", got_win[0], WIN_FIRST);
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < NPIX; i++) fp[f][i] = PW'($urandom_range(0, 255));
        end
        run(3, 2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
Streaming 3x3 neighbourhood generator, parametrised in pixel width and image size. It takes a raster-order pixel stream of an already-padded image and produces one 9-pixel window per interior position. Windows are output in row-major order, with full valid/ready backpressure on both sides. It sits between the pixel source and the per-window processing cores. It replaces the fixed 258-wide, whole-frame, preloaded window read with two line buffers, so frame height is unbounded by storage.

Parameters:
PIX_W, 8, bits per pixel
IMG_W, 258, padded image width in pixels (>=3)
IMG_H, 34, padded image height in pixels (>=3)
COL_W, $clog2(IMG_W), column counter width (derived, not overridden)
ROW_W, $clog2(IMG_H), row counter width (derived, not overridden)

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  in_pixel is valid
in_ready  out  1  block accepts in_pixel this cycle
in_pixel  in  PIX_W  raster-order pixel
out_valid  out  1  out_win holds a valid window
out_ready  in  1  consumer accepts out_win this cycle
out_win  out  9*PIX_W  window; w0 at LSBs … w8 at MSBs, row-major, w0 = top-left
frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

Behaviour:
- Reset (rst_n=0 at clk edge):
  - col, row, out_valid, frame_done <= 0; out_win <= 0.
  - Line buffer RAM is not cleared.
  - Reset mid-frame drops the partial frame; the next accepted pixel is (row 0, col 0).
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- On accept at (row, col) with pixel p:
  - Read lb1[col] (row-2) and lb0[col] (row-1).
  - Write lb1[col] <= lb0[col] and lb0[col] <= p.
  - Shift the 3-column tap registers: top/mid/bottom <= {lb1[col], lb0[col], p}.
- Window condition: row>=2 && col>=2.
  - On accept with the window condition true: out_win <= taps incl. new column, out_valid <= 1, next cycle (latency 1).
  - w0 = (row-2, col-2), w2 = (row-2, col), w6 = (row, col-2), w8 = p.
- On accept with the window condition false: out_valid <= 0. This is legal because acceptance implies the previous window was consumed or absent.
- No accept and out_ready=1: out_valid <= 0.
- No accept and out_ready=0: out_valid and out_win held stable.
- Back-to-back: out_ready=1 with a new window accepted in the same cycle replaces out_win without a bubble. Sustained throughput is 1 pixel/clk.
- Counters:
  - col wraps IMG_W-1 -> 0 and increments row.
  - row wraps IMG_H-1 -> 0.
  - frame_done <= 1 for exactly one cycle on accept at (IMG_H-1, IMG_W-1), else 0.
- Windows per frame: (IMG_W-2)*(IMG_H-2). No window straddles a row boundary; taps at col 0..1 are refilled before use.
- Stale line-buffer data from the previous frame is never exposed, because rows 0..1 produce no windows.
- in_valid low: no state changes except out_valid dropping on out_ready.

Optional Feature:
WINGEN_LAST_EN
- Defined: adds outputs out_eol (1) and out_eof (1), registered alongside out_win and held with it under backpressure.
  - out_eol=1 on a window whose col=IMG_W-1.
  - out_eof=1 on the window whose row=IMG_H-1 and col=IMG_W-1.
  - Both reset to 0.
- Undefined: ports absent; behaviour otherwise identical.

Decomposition:
- Shared package win_pkg:
  - pixel_t (logic [PIX_W-1:0]).
  - WIN_TAPS=9 and tap index constants W_TL..W_BR (0..8).
  - function pack_win(top, mid, bot column triples) -> 9*PIX_W vector.
- One sub-module: line_buf_2row. It is an IMG_W-deep, 2*PIX_W-wide single-port RAM with read-before-write on the same address, holding {lb1, lb0}.
- Counters, taps and output register remain in window_gen_3x3.

Test Plan:
- IMG_W=5, IMG_H=4, pixels 0..19, in_valid=1, out_ready=1 -> first out_valid the cycle after pixel 12 is accepted. Window = {0,1,2,5,6,7,10,11,12}; 6 windows total; last = {7,8,9,12,13,14,17,18,19}; frame_done pulses once, after pixel 19.
- Same stream with out_ready=0 for 4 cycles after the first window -> in_ready=0, out_win stable at {0..12 window}, no pixel lost. After release, the remaining windows match the golden model.
- Two frames back-to-back (second frame pixels 100..119) -> second-frame first window = {100,101,102,105,106,107,110,111,112}. No window mixes frame-1 data.
- rst_n=0 for 1 cycle after pixel 8 accepted, then a fresh stream 0..19 -> out_valid=0 the cycle after reset; output identical to the first scenario.
- Random in_valid/out_ready (50% each), IMG_W=258, IMG_H=34, random pixels -> 256*32 windows, all equal to a reference 3x3 extraction. out_win never changes while out_valid && !out_ready.
- WINGEN_LAST_EN defined, IMG_W=5, IMG_H=4 -> out_eol on windows ending at pixels 14 and 19; out_eof only on the pixel-19 window.
